// File: rtl/ambilight_pkg.sv
// Shared definitions for the ambilight memory stream reader.
// Holds the default memory geometry, the read latency and the
// controller state encoding.
package ambilight_pkg;

  localparam int ADDR_W       = 12;
  localparam int MEM_WORDS    = 4000;
  localparam int READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Next word address with wrap. Uses >= so an out-of-range start
  // address also folds back to 0 instead of running past the memory.
  function automatic logic [31:0] wrap_next(input logic [31:0] addr,
                                            input logic [31:0] words);
    return (addr >= words - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/ambilight_sync_fifo.sv
// Small first-word-fall-through FIFO used as the prefetch buffer.
// The head entry is visible on head_data whenever the FIFO is not
// empty; head_data reads as zero while empty. Flush empties it in
// one cycle and wins over a push or pop in the same cycle.
module ambilight_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en;
  logic             rd_en;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign level     = level_q;
  assign wr_en     = push & ~flush;
  assign rd_en     = pop & ~empty & ~flush;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_en) begin
        level_d = level_q + LVL_W'(1);
      end else if (rd_en && !wr_en) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // Control registers return to the empty state on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  // A push into a full FIFO without a simultaneous pop would overwrite the oldest word.
  ap_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/ambilight_mem_stream_reader.sv
// Avalon-MM read master on the second port of the frame/colour memory.
// Reads a contiguous, wrapping run of words with one cycle read latency
// and hands them to the LED path over a valid/ready stream. Reads are
// only issued while the prefetch FIFO has room for every outstanding
// word, so downstream backpressure never loses a returning word.
module ambilight_mem_stream_reader #(
  parameter int ADDR_W     = ambilight_pkg::ADDR_W,
  parameter int MEM_WORDS  = ambilight_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  import ambilight_pkg::state_e;
  import ambilight_pkg::ST_IDLE;
  import ambilight_pkg::ST_RUN;
  import ambilight_pkg::ST_DRAIN;
  import ambilight_pkg::wrap_next;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  popped_q, popped_d;
  logic              inflight_q, inflight_d;
  logic              last_acc_q, last_acc_d;
  logic              done_q, done_d;

  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;

  logic              busy_w;
  logic              abort_act;
  logic              credit_ok;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;

  // Abort only has an effect while a transfer is active.
  assign busy_w    = (state_q != ST_IDLE);
  assign abort_act = abort & busy_w;

  // Credit: words already buffered plus the one possibly in flight must
  // leave room for another. Uses registered level, so space freed by a
  // pop is only usable on the following cycle.
  assign credit_ok = (fifo_level + LVL_W'(inflight_q)) < LVL_W'(FIFO_DEPTH);

  // A read is issued combinationally in RUN; abort suppresses it in the same cycle.
  assign issue      = (state_q == ST_RUN) & ~abort & (issued_q < count_q) & credit_ok;
  assign last_issue = issue & ((issued_q + CNT_W'(1)) == count_q);

  // The word returning this cycle belongs to last cycle's read; drop it on abort.
  assign push = inflight_q & ~abort_act;
  assign pop  = st_valid & st_ready;

  ambilight_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort_act),
    .push      (push),
    .push_data (readdata),
    .pop       (pop),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Controller next-state: launch, issue bookkeeping, drain completion and abort.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    last_acc_d = last_acc_q;
    inflight_d = issue;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            // Empty transfer completes immediately without touching memory.
            done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            cur_addr_d = base_addr;
            count_d    = word_count;
            issued_d   = '0;
            popped_d   = '0;
            last_acc_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          cur_addr_d = ADDR_W'(wrap_next(32'(cur_addr_q), 32'(MEM_WORDS)));
          issued_d   = issued_q + CNT_W'(1);
        end
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_empty && last_acc_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Track how many words the consumer has taken; the head index drives st_last.
    if (pop) begin
      popped_d = popped_q + CNT_W'(1);
      if (st_last) last_acc_d = 1'b1;
    end

    if (abort_act) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      last_acc_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      last_acc_q <= last_acc_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_w;
  assign done       = done_q;
  assign address    = cur_addr_q;
  assign chipselect = issue;
  assign write      = 1'b0;
  assign byteenable = 4'hF;
  assign st_valid   = ~fifo_empty;
  assign st_data    = fifo_head;
  assign st_last    = st_valid & (popped_q == (count_q - CNT_W'(1)));

  // The credit rule must keep every returning word within FIFO capacity.
  ap_credit_holds: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule
